fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; legal values 2, 4, 8, 16.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Instr1_IN  input  32  instruction word produced by fetch.
REQ-005 SHALL have port Instr_PC_IN  input  32  address of that instruction.
REQ-006 SHALL have port Instr_PC_Plus4_IN  input  32  address following that instruction.
REQ-007 SHALL have port Valid_IN  input  1  fetch presents a new instruction this cycle.
REQ-008 SHALL have port Consume_IN  input  1  decode takes the head entry this cycle.
REQ-009 SHALL have port Flush  input  1  discard all entries (taken branch / redirect).
REQ-010 SHALL have port Instr1_OUT  output  32  head instruction; 0 (NOP) when empty.
REQ-011 SHALL have port Instr_PC_OUT  output  32  head instruction address; 0 when empty.
REQ-012 SHALL have port Instr_PC_Plus4_OUT  output  32  head next address; 0 when empty.
REQ-013 SHALL have port Valid_OUT  output  1  head entry holds a valid instruction.
REQ-014 SHALL have port STALL_2IF  output  1  queue full; fetch shall freeze.
REQ-015 SHALL have port Count_OUT  output  5  number of occupied entries, 0..DEPTH.

Function
REQ-016 SHALL store entries as {Instr1, PC, PC_Plus4} triples in circular storage with head and tail pointers of log2(DEPTH) bits wrapping modulo DEPTH.
REQ-017 SHALL derive all outputs combinationally from registered state only (head entry, count); no input-to-output combinational path.
REQ-018 SHALL accept a push when Valid_IN=1 and (count<DEPTH or Consume_IN=1 with count>0), writing at tail and advancing tail by 1.
REQ-019 SHALL perform a pop when Consume_IN=1 and count>0, advancing head by 1.
REQ-020 SHALL ignore Consume_IN when count=0 (no pointer or count change).
REQ-021 SHALL ignore Valid_IN when count=DEPTH and no pop occurs that cycle; entry dropped, state unchanged.
REQ-022 SHALL keep count unchanged on simultaneous accepted push and pop, including at count=DEPTH.
REQ-023 SHALL have one-cycle latency: a push into an empty queue becomes visible on outputs (Valid_OUT=1) the cycle after the accepting edge; no bypass.
REQ-024 SHALL assert STALL_2IF exactly when count=DEPTH.
REQ-025 SHALL, on Flush=1 at a clock edge, set count, head and tail to 0 and discard any concurrent push and pop; Flush dominates Valid_IN and Consume_IN.
REQ-026 SHALL drive Valid_OUT=1 exactly when count>0, and force Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT to 0 when count=0.
REQ-027 SHALL preserve FIFO order: entries leave in exactly the order accepted, across pointer wrap-around.

Reset
REQ-028 SHALL, while RESET=0, immediately and independently of CLK force count, head, tail to 0, making Valid_OUT=0, STALL_2IF=0, Count_OUT=0 and all 32-bit outputs 0.
REQ-029 SHALL leave storage array contents unspecified after reset; they shall never be visible while count=0.
REQ-030 SHALL, on RESET assertion mid-operation (queue non-empty, push/pop in flight), discard all entries with no partial update surviving.

Verification
REQ-031 SHALL cover: reset release, push {Instr 0x3C080001, PC 0xBFC00000, PC+4 0xBFC00004} -> next cycle Valid_OUT=1, outputs equal pushed triple, Count_OUT=1.
REQ-032 SHALL cover: DEPTH=4, pushes of PCs 0xBFC00000..0xBFC0000C with no consume -> STALL_2IF=1 after fourth edge; fifth push (PC 0xBFC00010) dropped; consumes return the four PCs in order.
REQ-033 SHALL cover: full queue, Valid_IN=1 and Consume_IN=1 same cycle -> Count_OUT stays 4, head advances, new PC appears last.
REQ-034 SHALL cover: 10 push/pop cycles forcing pointer wrap with PCs incrementing by 4 -> output PC sequence strictly increasing by 4, no duplicates or gaps.
REQ-035 SHALL cover: Count_OUT=3 with Flush=1, Valid_IN=1, Consume_IN=1 same edge -> Count_OUT=0, Valid_OUT=0, Instr1_OUT=0 next cycle.
REQ-036 SHALL cover: RESET pulsed low between clock edges with Count_OUT=2 -> outputs 0 and STALL_2IF=0 before the next posedge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between fetch and decode.
// Holds {instruction, PC, PC+4} triples; the head entry is presented
// combinationally from registered state, zeroed whenever the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr_PC_IN,
    input  logic [31:0] Instr_PC_Plus4_IN,
    input  logic        Valid_IN,
    input  logic        Consume_IN,
    input  logic        Flush,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Valid_OUT,
    output logic        STALL_2IF,
    output logic [4:0]  Count_OUT
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [4:0]      count;

    logic            pop_ok;
    logic            push_ok;
    logic            empty;

    // Handshake qualification; a full queue still accepts a push when a pop frees the head slot.
    always_comb begin
        empty   = (count == '0);
        pop_ok  = Consume_IN && !empty;
        push_ok = Valid_IN && ((count < DEPTH_C) || pop_ok);
    end

    // Pointer and occupancy state; flush dominates any concurrent push or pop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (Flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop_ok)
                head <= head + PW'(1);
            if (push_ok)
                tail <= tail + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are never reset since empty-queue outputs are masked.
    always_ff @(posedge CLK) begin
        if (push_ok && !Flush)
            mem[tail] <= '{instr: Instr1_IN, pc: Instr_PC_IN, pc_plus4: Instr_PC_Plus4_IN};
    end

    // Head presentation and status flags, driven only from registered state.
    always_comb begin
        Valid_OUT          = !empty;
        STALL_2IF          = (count == DEPTH_C);
        Count_OUT          = count;
        Instr1_OUT         = '0;
        Instr_PC_OUT       = '0;
        Instr_PC_Plus4_OUT = '0;
        if (!empty) begin
            Instr1_OUT         = mem[head].instr;
            Instr_PC_OUT       = mem[head].pc;
            Instr_PC_Plus4_OUT = mem[head].pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

    logic        CLK;
    logic        RESET;
    logic [31:0] Instr1_IN;
    logic [31:0] Instr_PC_IN;
    logic [31:0] Instr_PC_Plus4_IN;
    logic        Valid_IN;
    logic        Consume_IN;
    logic        Flush;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        Valid_OUT;
    logic        STALL_2IF;
    logic [4:0]  Count_OUT;

    int unsigned tests_run = 0;
    int unsigned failures  = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Instr1_IN         (Instr1_IN),
        .Instr_PC_IN       (Instr_PC_IN),
        .Instr_PC_Plus4_IN (Instr_PC_Plus4_IN),
        .Valid_IN          (Valid_IN),
        .Consume_IN        (Consume_IN),
        .Flush             (Flush),
        .Instr1_OUT        (Instr1_OUT),
        .Instr_PC_OUT      (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
        .Valid_OUT         (Valid_OUT),
        .STALL_2IF         (STALL_2IF),
        .Count_OUT         (Count_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Valid_IN   = 1'b0;
        Consume_IN = 1'b0;
        Flush      = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] instr, input logic [31:0] pc);
        Valid_IN          = 1'b1;
        Instr1_IN         = instr;
        Instr_PC_IN       = pc;
        Instr_PC_Plus4_IN = pc + 32'd4;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        Instr1_IN = '0; Instr_PC_IN = '0; Instr_PC_Plus4_IN = '0;
        idle_inputs();
        #1 RESET = 1'b0;
        #1;
        tests_run++;
        if (Valid_OUT !== 1'b0 || STALL_2IF !== 1'b0 || Count_OUT !== 5'd0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b stall=%b count=%0d, required 0 0 0", Valid_OUT, STALL_2IF, Count_OUT);
        end
        tests_run++;
        if (Instr1_OUT !== 32'h0 || Instr_PC_OUT !== 32'h0 || Instr_PC_Plus4_OUT !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: instr=%h pc=%h pc4=%h, required zeros", Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT);
        end
        cycle();
        RESET = 1'b1;
        cycle();
        tests_run++;
        if (Count_OUT !== 5'd0 || Valid_OUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: count=%0d valid=%b, required 0 0", Count_OUT, Valid_OUT);
        end
    endtask

    task automatic test_single_push();
        set_push(32'h3C080001, 32'hBFC00000);
        #3;
        tests_run++;
        if (Valid_OUT !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass: valid=%b before edge, required 0", Valid_OUT);
        end
        cycle();
        idle_inputs();
        tests_run++;
        if (Valid_OUT !== 1'b1 || Count_OUT !== 5'd1 || Instr1_OUT !== 32'h3C080001 ||
            Instr_PC_OUT !== 32'hBFC00000 || Instr_PC_Plus4_OUT !== 32'hBFC00004) begin
            failures++;
            $display("FAIL single_push: valid=%b count=%0d instr=%h pc=%h pc4=%h, required 1 1 3c080001 bfc00000 bfc00004",
                     Valid_OUT, Count_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT);
        end
        Consume_IN = 1'b1;
        cycle();
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd0 || Valid_OUT !== 1'b0 || Instr1_OUT !== 32'h0 || Instr_PC_OUT !== 32'h0) begin
            failures++;
            $display("FAIL single_pop: count=%0d valid=%b instr=%h pc=%h, required 0 0 0 0", Count_OUT, Valid_OUT, Instr1_OUT, Instr_PC_OUT);
        end
    endtask

    task automatic test_consume_empty();
        Consume_IN = 1'b1;
        cycle();
        cycle();
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd0 || Valid_OUT !== 1'b0) begin
            failures++;
            $display("FAIL consume_empty: count=%0d valid=%b, required 0 0", Count_OUT, Valid_OUT);
        end
        set_push(32'hAAAA0001, 32'h00001000);
        cycle();
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd1 || Instr_PC_OUT !== 32'h00001000 || Instr1_OUT !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL push_after_empty_consume: count=%0d pc=%h instr=%h, required 1 00001000 aaaa0001", Count_OUT, Instr_PC_OUT, Instr1_OUT);
        end
        Consume_IN = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_fill_and_drop();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h10000000 + 32'(i), 32'hBFC00000 + 32'(4 * i));
            cycle();
        end
        idle_inputs();
        tests_run++;
        if (STALL_2IF !== 1'b1 || Count_OUT !== 5'd4) begin
            failures++;
            $display("FAIL fill_stall: stall=%b count=%0d, required 1 4", STALL_2IF, Count_OUT);
        end
        set_push(32'h10000004, 32'hBFC00010);
        cycle();
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd4 || Instr_PC_OUT !== 32'hBFC00000) begin
            failures++;
            $display("FAIL full_drop: count=%0d head_pc=%h, required 4 bfc00000", Count_OUT, Instr_PC_OUT);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (Instr_PC_OUT !== 32'hBFC00000 + 32'(4 * i) || Instr1_OUT !== 32'h10000000 + 32'(i)) begin
                failures++;
                $display("FAIL drain_order[%0d]: pc=%h instr=%h, required %h %h", i, Instr_PC_OUT, Instr1_OUT,
                         32'hBFC00000 + 32'(4 * i), 32'h10000000 + 32'(i));
            end
            Consume_IN = 1'b1;
            cycle();
            idle_inputs();
        end
        tests_run++;
        if (Count_OUT !== 5'd0 || STALL_2IF !== 1'b0 || Valid_OUT !== 1'b0) begin
            failures++;
            $display("FAIL drained: count=%0d stall=%b valid=%b, required 0 0 0", Count_OUT, STALL_2IF, Valid_OUT);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h20000000 + 32'(i), 32'h00000100 + 32'(4 * i));
            cycle();
        end
        set_push(32'h20000004, 32'h00000110);
        Consume_IN = 1'b1;
        cycle();
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd4 || STALL_2IF !== 1'b1 || Instr_PC_OUT !== 32'h00000104) begin
            failures++;
            $display("FAIL full_push_pop: count=%0d stall=%b head_pc=%h, required 4 1 00000104", Count_OUT, STALL_2IF, Instr_PC_OUT);
        end
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if (Instr_PC_OUT !== 32'h00000100 + 32'(4 * i)) begin
                failures++;
                $display("FAIL full_push_pop_order[%0d]: pc=%h, required %h", i, Instr_PC_OUT, 32'h00000100 + 32'(4 * i));
            end
            Consume_IN = 1'b1;
            cycle();
            idle_inputs();
        end
    endtask

    task automatic test_wrap();
        set_push(32'h30000000, 32'h00002000);
        cycle();
        for (int i = 1; i <= 10; i++) begin
            tests_run++;
            if (Instr_PC_OUT !== 32'h00002000 + 32'(4 * (i - 1)) || Count_OUT !== 5'd1 ||
                Instr_PC_Plus4_OUT !== 32'h00002000 + 32'(4 * i)) begin
                failures++;
                $display("FAIL wrap[%0d]: pc=%h pc4=%h count=%0d, required %h %h 1", i, Instr_PC_OUT, Instr_PC_Plus4_OUT,
                         Count_OUT, 32'h00002000 + 32'(4 * (i - 1)), 32'h00002000 + 32'(4 * i));
            end
            set_push(32'h30000000 + 32'(i), 32'h00002000 + 32'(4 * i));
            Consume_IN = 1'b1;
            cycle();
        end
        idle_inputs();
        tests_run++;
        if (Instr_PC_OUT !== 32'h00002028 || Count_OUT !== 5'd1) begin
            failures++;
            $display("FAIL wrap_last: pc=%h count=%0d, required 00002028 1", Instr_PC_OUT, Count_OUT);
        end
        Consume_IN = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_push(32'h40000000 + 32'(i), 32'h00003000 + 32'(4 * i));
            cycle();
        end
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd3) begin
            failures++;
            $display("FAIL flush_setup: count=%0d, required 3", Count_OUT);
        end
        set_push(32'h40000003, 32'h0000300C);
        Consume_IN = 1'b1;
        Flush      = 1'b1;
        cycle();
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd0 || Valid_OUT !== 1'b0 || Instr1_OUT !== 32'h0 || Instr_PC_OUT !== 32'h0) begin
            failures++;
            $display("FAIL flush: count=%0d valid=%b instr=%h pc=%h, required 0 0 0 0", Count_OUT, Valid_OUT, Instr1_OUT, Instr_PC_OUT);
        end
        set_push(32'h40000010, 32'h00003100);
        cycle();
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd1 || Instr_PC_OUT !== 32'h00003100) begin
            failures++;
            $display("FAIL post_flush_push: count=%0d pc=%h, required 1 00003100", Count_OUT, Instr_PC_OUT);
        end
        Consume_IN = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            set_push(32'h50000000 + 32'(i), 32'h00004000 + 32'(4 * i));
            cycle();
        end
        set_push(32'h50000002, 32'h00004008);
        Consume_IN = 1'b1;
        #3 RESET = 1'b0;
        #1;
        tests_run++;
        if (Count_OUT !== 5'd0 || Valid_OUT !== 1'b0 || STALL_2IF !== 1'b0 ||
            Instr1_OUT !== 32'h0 || Instr_PC_OUT !== 32'h0 || Instr_PC_Plus4_OUT !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: count=%0d valid=%b stall=%b instr=%h pc=%h pc4=%h, required all 0",
                     Count_OUT, Valid_OUT, STALL_2IF, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT);
        end
        cycle();
        tests_run++;
        if (Count_OUT !== 5'd0 || Valid_OUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_holds: count=%0d valid=%b, required 0 0", Count_OUT, Valid_OUT);
        end
        idle_inputs();
        #2 RESET = 1'b1;
        cycle();
        tests_run++;
        if (Count_OUT !== 5'd0 || Valid_OUT !== 1'b0 || Instr_PC_OUT !== 32'h0) begin
            failures++;
            $display("FAIL after_reset: count=%0d valid=%b pc=%h, required 0 0 0", Count_OUT, Valid_OUT, Instr_PC_OUT);
        end
        set_push(32'h50000010, 32'h00004100);
        cycle();
        idle_inputs();
        tests_run++;
        if (Count_OUT !== 5'd1 || Instr_PC_OUT !== 32'h00004100) begin
            failures++;
            $display("FAIL push_after_reset: count=%0d pc=%h, required 1 00004100", Count_OUT, Instr_PC_OUT);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_consume_empty();
        test_fill_and_drop();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
